bru_issue_queue: RTL
====================

// Module: bru_issue_queue
// PURPOSE
// - Collapsing issue queue that buffers dispatched branch/jump ops until both source operands are ready.
// - Tracks operand readiness from writeback wakeup broadcasts.
// - Selects the oldest ready entry and hands it to the single BRU via valid/allowin.
// - Sits between dispatch/rename and the BRU execute stage.
// PARAMETERS
// - DEPTH       4   entries (2..16)
// - PREG_W      6   physical register tag width
// - PAYLOAD_W   128 opaque issue payload width (pc, decoded inst, phy_dest, prediction, exception)
// - WAKE_PORTS  3   wakeup broadcast ports
// PORTS
// - clk               in   1                 clock; all state updates on posedge
// - reset             in   1                 synchronous, active-high
// - flush             in   1                 pipeline flush (mispredict/exception)
// - dispatch_valid    in   1                 dispatch offers one op
// - dispatch_ready    out  1                 queue accepts; = (count < DEPTH)
// - dispatch_src1     in   PREG_W            src1 physical tag
// - dispatch_src1_rdy in   1                 src1 already available
// - dispatch_src2     in   PREG_W            src2 physical tag
// - dispatch_src2_rdy in   1                 src2 already available
// - dispatch_payload  in   PAYLOAD_W         carried unchanged to BRU
// - wake_valid        in   WAKE_PORTS        broadcast valid per port
// - wake_tag          in   WAKE_PORTS*PREG_W destination tag per port; port i = bits [i*PREG_W +: PREG_W]
// - issue_to_bru_valid out 1                 selected entry valid
// - bru_allowin       in   1                 BRU accepts this cycle
// - issue_payload     out  PAYLOAD_W         payload of selected entry
// - count             out  $clog2(DEPTH+1)   occupied entries
// BEHAVIOUR
// - Reset: all entries invalid, count=0, dispatch_ready=1, issue_to_bru_valid=0, issue_payload=0.
// - Storage: entries 0..count-1 valid, index 0 = oldest; no holes.
// - Entry fields: valid, src1 tag, src1 rdy, src2 tag, src2 rdy, payload.
// - Wakeup: each registered edge, any valid entry with tag == wake_tag[i] and wake_valid[i] sets that rdy bit.
//   - Tag 0 gets no special treatment.
//   - No same-cycle wakeup-to-issue: an op woken in cycle N issues at the earliest in cycle N+1.
// - Dispatch write: dispatch_valid && dispatch_ready.
//   - Written at index count, or count-1 if an issue fires the same cycle.
//   - Each rdy bit = dispatch_srcX_rdy OR a matching same-cycle wake.
// - dispatch_ready depends only on count, never on bru_allowin.
//   - A full queue refuses dispatch even when an issue fires that cycle.
// - Select: lowest index with valid && src1_rdy && src2_rdy; selection is combinational from registered state.
//   - issue_to_bru_valid = any selectable && !flush.
//   - issue_payload = selected payload, or 0 if none.
// - Issue fires when issue_to_bru_valid && bru_allowin.
//   - Selected entry removed at the edge; entries above it shift down by one, keeping age order.
//   - Wakeups that cycle apply to the shifted entries.
// - count_next = count + dispatch_fire - issue_fire.
// - Flush: at the edge, all entries invalid and count=0. Same-cycle dispatch is dropped; no issue fires.
// - Reset has priority over flush; flush has priority over dispatch/issue/wakeup.
// - Latency: dispatch with both rdy=1 into an empty queue -> issue_to_bru_valid high the next cycle.
// - Assertions:
//   - count <= DEPTH.
//   - No dispatch_valid && dispatch_ready while count == DEPTH.
//   - Entries are contiguous.
// CONFIGURATION
// - Macro BRU_IQ_INORDER_EN.
// - Defined:
//   - Only entry 0 is eligible; issue_to_bru_valid = entry0 valid && both rdy && !flush.
//   - Younger ready ops wait behind an unready head, so branches resolve in program order.
// - Undefined (default): oldest-ready out-of-order select as above.
// TESTING
// - Reset, then dispatch A (rdy 1/1) at cycle 1 -> valid=1 at cycle 2 with A's payload; allowin=1 -> count=0 at cycle 3.
// - A (src1=5 unready), B ready; wake tag 5 at cycle 3.
//   - OoO: B issues first, A at cycle 4.
//   - With BRU_IQ_INORDER_EN: B held until A issues.
// - Fill 4 entries -> dispatch_ready=0; issue + dispatch in same cycle -> dispatch refused, count=3.
// - count=3, issue index 1 + dispatch D in same cycle -> order [0, 2, D], count=3.
// - Dispatch src2=9 unready with wake tag 9 in the same cycle -> entry rdy, issues the next cycle.
// - count=3, flush with dispatch_valid=1 and allowin=1 -> no issue; next cycle count=0, valid=0.

Source files
------------

// File: rtl/bru_issue_queue.sv
// Collapsing issue queue for the branch unit: holds ops until both sources are ready, then issues the oldest ready one.
// Optional macro BRU_IQ_INORDER_EN restricts issue to the head entry only (in-order branch resolution).
module bru_issue_queue #(
  parameter int DEPTH      = 4,
  parameter int PREG_W     = 6,
  parameter int PAYLOAD_W  = 128,
  parameter int WAKE_PORTS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         dispatch_valid,
  output logic                         dispatch_ready,
  input  logic [PREG_W-1:0]            dispatch_src1,
  input  logic                         dispatch_src1_rdy,
  input  logic [PREG_W-1:0]            dispatch_src2,
  input  logic                         dispatch_src2_rdy,
  input  logic [PAYLOAD_W-1:0]         dispatch_payload,
  input  logic [WAKE_PORTS-1:0]        wake_valid,
  input  logic [WAKE_PORTS*PREG_W-1:0] wake_tag,
  output logic                         issue_to_bru_valid,
  input  logic                         bru_allowin,
  output logic [PAYLOAD_W-1:0]         issue_payload,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]     ent_valid, ent_r1, ent_r2;
  logic [PREG_W-1:0]    ent_s1  [DEPTH];
  logic [PREG_W-1:0]    ent_s2  [DEPTH];
  logic [PAYLOAD_W-1:0] ent_pay [DEPTH];

  logic [DEPTH-1:0]     n_valid, n_r1, n_r2;
  logic [PREG_W-1:0]    n_s1  [DEPTH];
  logic [PREG_W-1:0]    n_s2  [DEPTH];
  logic [PAYLOAD_W-1:0] n_pay [DEPTH];
  logic [CNT_W-1:0]     n_count;

  logic [DEPTH-1:0] ready_vec;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             issue_fire;
  logic             dispatch_fire;
  logic [CNT_W-1:0] wr_idx;

  function automatic logic wake_hit(input logic [PREG_W-1:0] tag,
                                    input logic [WAKE_PORTS-1:0] wv,
                                    input logic [WAKE_PORTS*PREG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      if (wv[p] && (wt[p*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign ready_vec      = ent_valid & ent_r1 & ent_r2;
  assign dispatch_ready = (count < CNT_W'(DEPTH));

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef BRU_IQ_INORDER_EN
    sel_found = ready_vec[0];
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
`endif
  end

  assign issue_to_bru_valid = sel_found && !flush;
  assign issue_payload      = sel_found ? ent_pay[sel_idx] : '0;
  assign issue_fire         = issue_to_bru_valid && bru_allowin;
  assign dispatch_fire      = dispatch_valid && dispatch_ready && !flush;
  assign wr_idx             = count - CNT_W'(issue_fire);

  // Collapse above the issued slot, then apply wakeups, then append the dispatched op.
  always_comb begin
    n_valid = '0;
    n_r1    = '0;
    n_r2    = '0;
    n_count = count;
    for (int i = 0; i < DEPTH; i++) begin
      int j;
      j = (issue_fire && (IDX_W'(i) >= sel_idx)) ? i + 1 : i;
      n_s1[i]  = '0;
      n_s2[i]  = '0;
      n_pay[i] = '0;
      if (j < DEPTH) begin
        n_valid[i] = ent_valid[IDX_W'(j)];
        n_r1[i]    = ent_r1[IDX_W'(j)];
        n_r2[i]    = ent_r2[IDX_W'(j)];
        n_s1[i]    = ent_s1[IDX_W'(j)];
        n_s2[i]    = ent_s2[IDX_W'(j)];
        n_pay[i]   = ent_pay[IDX_W'(j)];
      end
      if (n_valid[i]) begin
        n_r1[i] = n_r1[i] | wake_hit(n_s1[i], wake_valid, wake_tag);
        n_r2[i] = n_r2[i] | wake_hit(n_s2[i], wake_valid, wake_tag);
      end
      if (dispatch_fire && (CNT_W'(i) == wr_idx)) begin
        n_valid[i] = 1'b1;
        n_s1[i]    = dispatch_src1;
        n_s2[i]    = dispatch_src2;
        n_r1[i]    = dispatch_src1_rdy | wake_hit(dispatch_src1, wake_valid, wake_tag);
        n_r2[i]    = dispatch_src2_rdy | wake_hit(dispatch_src2, wake_valid, wake_tag);
        n_pay[i]   = dispatch_payload;
      end
    end
    n_count = count + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
    if (flush) begin
      n_valid = '0;
      n_count = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid <= '0;
      ent_r1    <= '0;
      ent_r2    <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_s1[i]  <= '0;
        ent_s2[i]  <= '0;
        ent_pay[i] <= '0;
      end
    end else begin
      ent_valid <= n_valid;
      ent_r1    <= n_r1;
      ent_r2    <= n_r2;
      count     <= n_count;
      for (int i = 0; i < DEPTH; i++) begin
        ent_s1[i]  <= n_s1[i];
        ent_s2[i]  <= n_s2[i];
        ent_pay[i] <= n_pay[i];
      end
    end
  end

`ifndef SYNTHESIS
  logic [DEPTH-1:0] contig_mask;
  always_comb begin
    contig_mask = '0;
    for (int i = 0; i < DEPTH; i++) contig_mask[i] = (CNT_W'(i) < count);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count <= CNT_W'(DEPTH));
      assert (!(dispatch_valid && dispatch_ready && (count == CNT_W'(DEPTH))));
      assert (ent_valid == contig_mask);
    end
  end
`endif

endmodule
